// File: rtl/spi_byte_engine_if.sv
// Register-block side of the SPI byte engine: transfer request, byte in/out and completion.
// The register block drives the request (master); the engine answers (slave).
interface spi_byte_engine_if;
    logic [8:0] divider;
    logic       xfer_start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       xfer_complete;

    modport master (
        output divider, xfer_start, tx_data,
        input  rx_data, xfer_complete
    );

    modport slave (
        input  divider, xfer_start, tx_data,
        output rx_data, xfer_complete
    );
endinterface

// File: rtl/spi_byte_engine.sv
// Byte-wide SPI mode-0 shifter: 16 sclk edges per byte, sclk half-period = divider+1 clk cycles.
// Define SPI_BYTE_ENGINE_LSB_FIRST_EN for LSB-first bit order; MSB-first otherwise.
module spi_byte_engine (
    input  logic              clk,
    input  logic              reset,
    spi_byte_engine_if.slave  bus,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;
    localparam logic [4:0] LAST_EDGE = 5'd15;

    logic [0:0] state_q,   state_d;
    logic [8:0] div_q,     div_d;
    logic [8:0] cnt_q,     cnt_d;
    logic [4:0] edge_q,    edge_d;
    logic [7:0] tx_sh_q,   tx_sh_d;
    logic [7:0] rx_sh_q,   rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       done_q,    done_d;
    logic       sclk_q,    sclk_d;
    logic       mosi_q,    mosi_d;

    // Bit-order dependent views of the shift registers.
    logic       first_bit;
    logic       next_bit;
    logic [7:0] tx_shifted;
    logic [7:0] rx_shifted;

`ifdef SPI_BYTE_ENGINE_LSB_FIRST_EN
    assign first_bit  = bus.tx_data[0];
    assign next_bit   = tx_sh_q[1];
    assign tx_shifted = {1'b0, tx_sh_q[7:1]};
    assign rx_shifted = {miso, rx_sh_q[7:1]};
`else
    assign first_bit  = bus.tx_data[7];
    assign next_bit   = tx_sh_q[6];
    assign tx_shifted = {tx_sh_q[6:0], 1'b0};
    assign rx_shifted = {rx_sh_q[6:0], miso};
`endif

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.xfer_start) begin
                    state_d = ST_ACTIVE;
                    div_d   = bus.divider;
                    tx_sh_d = bus.tx_data;
                    mosi_d  = first_bit;
                    cnt_d   = 9'd0;
                    edge_d  = 5'd0;
                    sclk_d  = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == div_q) begin
                    cnt_d  = 9'd0;
                    edge_d = edge_q + 5'd1;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_sh_d = rx_shifted;
                    end else if (edge_q == LAST_EDGE) begin
                        // The final rising edge already captured bit 8, so the byte is complete.
                        rx_data_d = rx_sh_q;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        tx_sh_d = tx_shifted;
                        mosi_d  = next_bit;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= 9'd0;
            cnt_q     <= 9'd0;
            edge_q    <= 5'd0;
            tx_sh_q   <= 8'h00;
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.xfer_complete = done_q;
    assign sclk              = sclk_q;
    assign mosi              = mosi_q;
endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: a cycle-level transfer model checked every cycle,
// plus literal latency / received-byte expectations for each scenario.
module tb_spi_byte_engine;
    logic clk;
    logic reset;
    logic miso;
    logic mosi;
    logic sclk;

    spi_byte_engine_if bus_if ();

    spi_byte_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .miso  (miso),
        .mosi  (mosi),
        .sclk  (sclk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave behaviour: loop mosi back, or return a fixed byte.
    logic       slave_loop = 1'b1;
    logic [7:0] slave_byte = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [7:0] b, input int i);
`ifdef SPI_BYTE_ENGINE_LSB_FIRST_EN
        return b[i];
`else
        return b[7-i];
`endif
    endfunction

    // Model state: k = clk edges since the accepted start edge, h = half-period in clk cycles.
    logic       m_active = 1'b0;
    logic       m_pend   = 1'b0;
    logic       m_comp;
    int         m_k      = 0;
    int         m_h      = 1;
    logic [7:0] m_tx     = 8'h00;
    logic [7:0] m_slave  = 8'h00;
    logic       m_loop   = 1'b1;
    logic [8:0] m_pdiv   = 9'd0;
    logic [7:0] m_ptx    = 8'h00;
    logic [7:0] m_rx     = 8'h00;
    logic       m_hold   = 1'b0;

    always @(negedge clk) begin
        logic e_sclk;
        logic e_mosi;
        int   e;
        if (reset) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_rx     = 8'h00;
            m_hold   = 1'b0;
            miso     = 1'b0;
            chk("rst_sclk", sclk, 0);
            chk("rst_mosi", mosi, 0);
            chk("rst_complete", bus_if.xfer_complete, 0);
            chk("rst_rx_data", bus_if.rx_data, 0);
        end else begin
            m_comp = 1'b0;
            if (m_pend) begin
                m_active = 1'b1;
                m_pend   = 1'b0;
                m_k      = 0;
                m_h      = int'(m_pdiv) + 1;
                m_tx     = m_ptx;
                m_loop   = slave_loop;
                m_slave  = slave_byte;
            end else if (m_active) begin
                m_k++;
                if (m_k == 16 * m_h) begin
                    m_active = 1'b0;
                    m_comp   = 1'b1;
                    m_rx     = m_loop ? m_tx : m_slave;
                    m_hold   = bit_of(m_tx, 7);
                end
            end
            if (m_active) begin
                e      = m_k / m_h;
                e_sclk = e[0];
                e_mosi = bit_of(m_tx, e / 2);
                miso   = m_loop ? e_mosi : bit_of(m_slave, e / 2);
            end else begin
                e_sclk = 1'b0;
                e_mosi = m_hold;
                miso   = 1'b0;
            end
            chk("sclk", sclk, e_sclk);
            chk("mosi", mosi, e_mosi);
            chk("xfer_complete", bus_if.xfer_complete, m_comp);
            chk("rx_data", bus_if.rx_data, m_rx);
            if (bus_if.xfer_start && !m_active) begin
                m_pend = 1'b1;
                m_pdiv = bus_if.divider;
                m_ptx  = bus_if.tx_data;
            end
        end
    end

    time t_start;

    // Called 2 time units after a clk rise; returns at the same phase.
    task automatic start_xfer(input logic [8:0] d, input logic [7:0] t);
        bus_if.divider    = d;
        bus_if.tx_data    = t;
        bus_if.xfer_start = 1'b1;
        @(posedge clk);
        t_start = $time;
        #2;
        bus_if.xfer_start = 1'b0;
    endtask

    task automatic wait_complete(output int lat);
        lat = -1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #2;
            if (bus_if.xfer_complete) begin
                lat = int'(($time - 2 - t_start) / 10);
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_complete: got timeout expected completion pulse");
        end
    endtask

    initial begin
        int lat;
        int extra;
        reset             = 1'b1;
        miso              = 1'b0;
        bus_if.divider    = 9'd0;
        bus_if.tx_data    = 8'h00;
        bus_if.xfer_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        repeat (20) @(posedge clk);
        #2;
        chk("idle_rx_data", bus_if.rx_data, 8'h00);
        chk("idle_sclk", sclk, 0);

        // Loopback, divider 0.
        slave_loop = 1'b1;
        start_xfer(9'd0, 8'hA5);
        chk("a5_first_mosi", mosi, bit_of(8'hA5, 0));
        wait_complete(lat);
        chk("a5_latency", lat, 16);
        chk("a5_rx", bus_if.rx_data, 8'hA5);
        $display("xfer div=0 tx=a5 lat=%0d rx=%02h", lat, bus_if.rx_data);

        // Fixed slave byte, divider 3.
        slave_loop = 1'b0;
        slave_byte = 8'hC3;
        start_xfer(9'd3, 8'h3C);
        wait_complete(lat);
        chk("3c_latency", lat, 64);
        chk("3c_rx", bus_if.rx_data, 8'hC3);
        $display("xfer div=3 tx=3c lat=%0d rx=%02h", lat, bus_if.rx_data);

        // Second start and input changes mid-transfer must be ignored.
        slave_loop = 1'b1;
        start_xfer(9'd1, 8'h96);
        repeat (9) @(posedge clk);
        #2;
        start_xfer(9'd7, 8'hFF);
        wait_complete(lat);
        chk("ignore_latency", lat, 22);
        chk("ignore_rx", bus_if.rx_data, 8'h96);
        $display("xfer div=1 tx=96 (restart ignored) rx=%02h", bus_if.rx_data);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (bus_if.xfer_complete) extra++;
        end
        chk("ignore_extra_completions", extra, 0);

        // Back-to-back: second start in the completion cycle.
        start_xfer(9'd0, 8'h5A);
        wait_complete(lat);
        chk("b2b1_latency", lat, 16);
        chk("b2b1_rx", bus_if.rx_data, 8'h5A);
        $display("xfer div=0 tx=5a lat=%0d rx=%02h", lat, bus_if.rx_data);
        start_xfer(9'd1, 8'hC3);
        chk("b2b2_no_pulse", bus_if.xfer_complete, 0);
        wait_complete(lat);
        chk("b2b2_latency", lat, 32);
        chk("b2b2_rx", bus_if.rx_data, 8'hC3);
        $display("xfer div=1 tx=c3 lat=%0d rx=%02h", lat, bus_if.rx_data);

        // Reset at the 5th sclk edge aborts the transfer.
        slave_loop = 1'b0;
        slave_byte = 8'h81;
        start_xfer(9'd1, 8'hE7);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_abort_sclk", sclk, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_sclk", sclk, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_complete", bus_if.xfer_complete, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("abort_rx", bus_if.rx_data, 8'h00);
        $display("xfer div=1 tx=e7 aborted by reset rx=%02h", bus_if.rx_data);
        slave_loop = 1'b1;
        start_xfer(9'd0, 8'h42);
        wait_complete(lat);
        chk("post_reset_latency", lat, 16);
        chk("post_reset_rx", bus_if.rx_data, 8'h42);
        $display("xfer div=0 tx=42 lat=%0d rx=%02h", lat, bus_if.rx_data);

        repeat (5) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
